// File: rtl/bus_gate_ctrl.sv
// bus_gate_ctrl: sequential gate controller for the shared processor bus.
// Drives the per-source tristate enables from the microsequencer's gate
// requests so that at most one source drives in any cycle and a dead cycle
// always separates two different drivers. Also captures the driven bus value
// and counts illegal multi-source requests.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   req          gate requests, one-hot or zero expected
//   bus_in       resolved bus value (read back)
//   en           registered one-hot-or-zero tristate enables
//   owner        index of the enabled source (valid while en != 0)
//   bus_idle     high when en == 0
//   bus_q        last captured bus value
//   cap_valid    pulse: bus_q updated at the last edge
//   conflict     pulse: multi-hot req sampled at the last edge
//   conflict_cnt saturating count of conflict events
module bus_gate_ctrl #(
  parameter int N_SRC = 4,
  parameter int WIDTH = 16,
  parameter int OW    = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] req,
  input  logic [WIDTH-1:0] bus_in,
  output logic [N_SRC-1:0] en,
  output logic [OW-1:0]    owner,
  output logic             bus_idle,
  output logic [WIDTH-1:0] bus_q,
  output logic             cap_valid,
  output logic             conflict,
  output logic [7:0]       conflict_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_TURN  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [N_SRC-1:0] en_q, en_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [WIDTH-1:0] bus_q_q, bus_q_d;
  logic             cap_valid_q, cap_valid_d;
  logic             conflict_q, conflict_d;
  logic [7:0]       cnt_q, cnt_d;

  logic             req_zero, req_one;
  logic [OW-1:0]    req_idx;

  // Request classification. A power-of-two test (x & (x-1)) == 0 separates
  // ONE from MULTI once ZERO is excluded.
  always_comb begin
    req_zero = (req == '0);
    req_one  = !req_zero && ((req & (req - N_SRC'(1))) == '0);
    req_idx  = '0;
    for (int i = 0; i < N_SRC; i++)
      if (req[i]) req_idx = OW'(i);
  end

  always_comb begin
    state_d     = state_q;
    en_d        = en_q;
    owner_d     = owner_q;
    conflict_d  = 1'b0;
    // Any cycle with a driver ends in a capture, including the final one.
    cap_valid_d = (en_q != '0);
    bus_q_d     = (en_q != '0) ? bus_in : bus_q_q;

    case (state_q)
      S_DRIVE: begin
        if (req != en_q) begin
          en_d = '0;
          if (req_zero) begin
            state_d = S_IDLE;
          end else if (req_one) begin
            // Different single source: insert the dead cycle.
            state_d = S_TURN;
          end else begin
            state_d    = S_IDLE;
            conflict_d = 1'b1;
          end
        end
      end
      default: begin
        // IDLE and TURN behave alike; TURN only exists to hold en low
        // for exactly one cycle between drivers.
        if (req_one) begin
          state_d = S_DRIVE;
          en_d    = req;
          owner_d = req_idx;
        end else begin
          state_d    = S_IDLE;
          conflict_d = !req_zero;
        end
      end
    endcase

    cnt_d = cnt_q;
    if (conflict_d && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      en_q        <= '0;
      owner_q     <= '0;
      bus_q_q     <= '0;
      cap_valid_q <= 1'b0;
      conflict_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      owner_q     <= owner_d;
      bus_q_q     <= bus_q_d;
      cap_valid_q <= cap_valid_d;
      conflict_q  <= conflict_d;
      cnt_q       <= cnt_d;
    end
  end

  assign en           = en_q;
  assign owner        = owner_q;
  assign bus_idle     = (en_q == '0);
  assign bus_q        = bus_q_q;
  assign cap_valid    = cap_valid_q;
  assign conflict     = conflict_q;
  assign conflict_cnt = cnt_q;

endmodule
